// File: rtl/rr_mux4_arbiter_if.sv
// Bus bundle for the round-robin 4:1 mux arbiter: requester side, downstream
// side and the status outputs.  The master modport is the arbiter's view; the
// slave modport is the view of the surrounding requesters/consumer.
interface rr_mux4_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]      req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ready;
  logic [1:0]      S;
  logic [3:0]      grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            busy;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, S, grant, out_valid, out_data, busy
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, S, grant, out_valid, out_data, busy
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 channel mux.
// One owner is chosen among four valid/data requesters; its index drives the
// registered mux select S and its data is forwarded downstream under a
// valid/ready handshake.  The owner keeps the grant until its beat transfers.
// Optional feature: define RR_BURST_EN to let an owner keep the grant for up
// to MAX_BURST back-to-back transfers before rotation is forced.
module rr_mux4_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst,
  rr_mux4_arbiter_if.master bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [1:0] arb_last;
  logic [1:0] winner;
  logic       xfer;

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end

`ifdef RR_BURST_EN
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
`endif

  // First valid requester in rotating order last+1 .. last+4; the owner
  // itself is considered last, so it only wins again when nobody else asks.
  function automatic logic [1:0] pick_winner(input logic [1:0] last,
                                             input logic [3:0] valid);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // State register: owner, grant, rotation pointer and burst count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= 2'd0;
      grant_q     <= 4'b0000;
      last_q      <= 2'd3;
`ifdef RR_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
`ifdef RR_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  // Next-state logic: arbitrate from IDLE, re-arbitrate on every transfer
  // against the same-cycle requests, and fall back to IDLE when the owner
  // withdraws without transferring.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    grant_d  = grant_q;
    last_d   = last_q;
`ifdef RR_BURST_EN
    burst_cnt_d = burst_cnt_q;
`endif
    xfer     = (state_q == BUSY) && bus.req_valid[s_q] && bus.out_ready;
    arb_last = (state_q == IDLE) ? last_q : s_q;
    winner   = pick_winner(arb_last, bus.req_valid);

    case (state_q)
      IDLE: begin
`ifdef RR_BURST_EN
        burst_cnt_d = '0;
`endif
        if (|bus.req_valid) begin
          state_d = BUSY;
          s_d     = winner;
          grant_d = 4'b0001 << winner;
        end
      end
      BUSY: begin
        if (xfer) begin
          last_d = s_q;
`ifdef RR_BURST_EN
          if (int'(burst_cnt_q) < MAX_BURST - 1) begin
            burst_cnt_d = burst_cnt_q + CW'(1);
          end else begin
            s_d         = winner;
            grant_d     = 4'b0001 << winner;
            burst_cnt_d = '0;
          end
`else
          s_d     = winner;
          grant_d = 4'b0001 << winner;
`endif
        end else if (!bus.req_valid[s_q]) begin
          state_d = IDLE;
          grant_d = 4'b0000;
`ifdef RR_BURST_EN
          burst_cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // Output logic: handshake signals come from the registered owner, and the
  // embedded 4:1 mux forwards the owner's data.
  always_comb begin
    bus.busy      = (state_q == BUSY);
    bus.S         = s_q;
    bus.grant     = grant_q;
    bus.out_valid = (state_q == BUSY) && bus.req_valid[s_q];
    bus.req_ready = grant_q & {4{bus.out_ready}};
    bus.out_data  = bus.req_data[int'(s_q)*DW +: DW];
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter.  Per-cycle records of inputs and
// expected outputs are pushed to a scoreboard queue when driven and popped
// and compared just before the next rising edge.
module tb_rr_mux4_arbiter;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam logic [31:0] DATA = 32'h33A5_1144;

  logic clk = 1'b0;
  logic rst;

  rr_mux4_arbiter_if #(.DW(DW)) bus ();

  rr_mux4_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] rv;
    logic       ordy;
    logic [1:0] s;
    logic [3:0] g;
    logic       ov;
    logic [7:0] od;
    logic [3:0] rr;
    logic       bz;
  } vec_t;

  vec_t table_q[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   own_all[5];
  int   own_alt[8];

  function automatic logic [7:0] dataOf(input int i);
    logic [31:0] d;
    d = DATA;
    return d[i*8 +: 8];
  endfunction

  function automatic vec_t idleRow(input string n, input logic r, input logic [3:0] rv,
                                   input logic ordy, input int s);
    vec_t v;
    v.name = n; v.rst = r; v.rv = rv; v.ordy = ordy;
    v.s = 2'(s); v.g = 4'b0000; v.ov = 1'b0; v.od = dataOf(s);
    v.rr = 4'b0000; v.bz = 1'b0;
    return v;
  endfunction

  function automatic vec_t busyRow(input string n, input logic r, input logic [3:0] rv,
                                   input logic ordy, input int owner);
    vec_t v;
    v.name = n; v.rst = r; v.rv = rv; v.ordy = ordy;
    v.s = 2'(owner); v.g = 4'b0001 << owner; v.ov = rv[owner];
    v.od = dataOf(owner); v.rr = ordy ? (4'b0001 << owner) : 4'b0000; v.bz = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    bus.req_valid = v.rv;
    bus.req_data  = DATA;
    bus.out_ready = v.ordy;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    #2;
    checks++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: no expected record queued");
      return;
    end
    e = exp_q.pop_front();
    if (bus.S !== e.s || bus.grant !== e.g || bus.out_valid !== e.ov ||
        bus.out_data !== e.od || bus.req_ready !== e.rr || bus.busy !== e.bz) begin
      $display("[TB] FAIL %s: got S=%0d grant=%b ov=%b od=%h rr=%b busy=%b, want S=%0d grant=%b ov=%b od=%h rr=%b busy=%b",
               e.name, bus.S, bus.grant, bus.out_valid, bus.out_data, bus.req_ready, bus.busy,
               e.s, e.g, e.ov, e.od, e.rr, e.bz);
    end else begin
      passes++;
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  task automatic runTable();
    foreach (table_q[i]) step(table_q[i]);
    table_q.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; bus.req_valid = 4'b0000; bus.req_data = DATA; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
`ifdef RR_BURST_EN
    own_all = '{0, 0, 0, 0, 1};
    own_alt = '{0, 0, 0, 0, 3, 3, 3, 3};
`else
    own_all = '{0, 1, 2, 3, 0};
    own_alt = '{0, 3, 0, 3, 0, 3, 0, 3};
`endif
    rst = 1'b1; bus.req_valid = 4'b0000; bus.req_data = DATA; bus.out_ready = 1'b0;
    doReset();

    // Reset held with all requests, then release: first grant goes to 0.
    table_q.push_back(idleRow("rst_hold", 1'b1, 4'b1111, 1'b1, 0));
    table_q.push_back(idleRow("rst_release", 1'b0, 4'b1111, 1'b1, 0));
    table_q.push_back(busyRow("first_grant", 1'b0, 4'b1111, 1'b0, 0));
    runTable();
    doReset();

    // Single requester 2, transfer, then drop valid -> IDLE.
    table_q.push_back(idleRow("single_idle", 1'b0, 4'b0100, 1'b1, 0));
    table_q.push_back(busyRow("single_xfer", 1'b0, 4'b0100, 1'b1, 2));
    table_q.push_back(busyRow("single_drop", 1'b0, 4'b0000, 1'b1, 2));
    table_q.push_back(idleRow("single_to_idle", 1'b0, 4'b0000, 1'b1, 2));
    table_q.push_back(idleRow("single_rearb", 1'b0, 4'b0001, 1'b0, 2));
    table_q.push_back(busyRow("single_next", 1'b0, 4'b0001, 1'b0, 0));
    runTable();
    doReset();

    // All four valid with out_ready high: rotation without bubbles.
    table_q.push_back(idleRow("all_idle", 1'b0, 4'b1111, 1'b1, 0));
    for (int i = 0; i < 5; i++)
      table_q.push_back(busyRow($sformatf("all_rot%0d", i), 1'b0, 4'b1111, 1'b1, own_all[i]));
    runTable();
    doReset();

    // Backpressure on owner 1 for five cycles, then one transfer.
    step(idleRow("bp_idle", 1'b0, 4'b0010, 1'b0, 0));
    for (int i = 0; i < 5; i++)
      step(busyRow($sformatf("bp_hold%0d", i), 1'b0, 4'b0110, 1'b0, 1));
    step(busyRow("bp_xfer", 1'b0, 4'b0110, 1'b1, 1));
`ifdef RR_BURST_EN
    step(busyRow("bp_next", 1'b0, 4'b0100, 1'b0, 1));
`else
    step(busyRow("bp_next", 1'b0, 4'b0100, 1'b0, 2));
`endif
    doReset();

    // Requesters 0 and 3 contending: alternation or bursts of MAX_BURST.
    table_q.push_back(idleRow("alt_idle", 1'b0, 4'b1001, 1'b1, 0));
    for (int i = 0; i < 8; i++)
      table_q.push_back(busyRow($sformatf("alt%0d", i), 1'b0, 4'b1001, 1'b1, own_alt[i]));
    runTable();
    doReset();

    // Owner withdraws without transfer, then reset during a transfer cycle.
    step(idleRow("viol_idle", 1'b0, 4'b1000, 1'b0, 0));
    step(busyRow("viol_owner", 1'b0, 4'b1000, 1'b0, 3));
    step(busyRow("viol_drop", 1'b0, 4'b0000, 1'b0, 3));
    step(idleRow("viol_to_idle", 1'b0, 4'b0000, 1'b0, 3));
    step(idleRow("viol_rearb", 1'b0, 4'b0011, 1'b0, 3));
    step(busyRow("viol_owner0", 1'b0, 4'b0011, 1'b0, 0));
    step(busyRow("midrst_busy", 1'b1, 4'b0011, 1'b1, 0));
    step(idleRow("midrst_idle", 1'b0, 4'b0011, 1'b1, 0));
    step(busyRow("midrst_regrant", 1'b0, 4'b0011, 1'b0, 0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
